// File: rtl/gray2binary_decoder.sv
// -----------------------------------------------------------------------------
// gray2binary_decoder
//
// Purpose:
//   Decodes a stream of N-bit Gray codes back to binary through one registered
//   output stage. Both sides use valid/ready handshakes, and the stage sustains
//   full throughput. A small monitor tracks the previously accepted code. For
//   each beat it reports whether the value advanced by +1 (mod 2^N) and,
//   optionally, whether the code moved by exactly one bit.
//
// Parameters:
//   N          code width in bits (N >= 2)
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high
//   in_valid   gray holds a code to accept
//   in_ready   decoder can accept this cycle (combinational)
//   gray       Gray-coded input word
//   out_valid  binary/dir_up/step_err are valid
//   out_ready  consumer accepts this cycle
//   binary     decoded binary value
//   dir_up     beat is the previous beat's value +1 (mod 2^N)
//   step_err   beat is not a single-bit step from the previous code
//   err_count  saturating count of step errors (G2B_STEP_CHECK_EN only)
//
// Configuration:
//   G2B_STEP_CHECK_EN  when defined, enables the single-bit step checker and
//                      the err_count port. When undefined, step_err is tied to
//                      0 and err_count does not exist.
// -----------------------------------------------------------------------------
module gray2binary_decoder #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] gray,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] binary,
  output logic         dir_up,
  output logic         step_err
`ifdef G2B_STEP_CHECK_EN
  ,
  output logic [7:0]   err_count
`endif
);

  typedef enum logic {
    S_FIRST = 1'b0,
    S_TRACK = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] prev_bin_q;
  logic [N-1:0] bin_new;
  logic [N-1:0] prev_inc;
  logic         accept;
  logic         dir_new;

  // Downstream stall is the only reason to refuse input.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign prev_inc = prev_bin_q + N'(1);

  // Decode with an MSB-first XOR prefix chain: b[i] = b[i+1] ^ g[i].
  // NOTE: every always_comb output gets a value before any conditional logic,
  // so no path can leave a signal unassigned and infer a latch.
  always_comb begin
    bin_new        = '0;
    bin_new[N-1]   = gray[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      bin_new[i] = bin_new[i+1] ^ gray[i];
    end
  end

  // The monitor FSM advances only on an accepted beat. The first beat after
  // reset has no predecessor, so it never counts as an up step.
  always_comb begin
    state_d = state_q;
    dir_new = 1'b0;
    if (state_q == S_TRACK) begin
      dir_new = (bin_new == prev_inc);
    end
    if (accept) begin
      state_d = S_TRACK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values no matter how the blocks are ordered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FIRST;
      out_valid  <= 1'b0;
      binary     <= '0;
      dir_up     <= 1'b0;
      prev_bin_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // A completion on the same edge is absorbed by overwriting the stage.
        out_valid  <= 1'b1;
        binary     <= bin_new;
        dir_up     <= dir_new;
        prev_bin_q <= bin_new;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef G2B_STEP_CHECK_EN
  logic [N-1:0] prev_gray_q;
  logic [N-1:0] diff;
  logic         err_new;

  // A repeated code (diff == 0) also counts as an illegal step.
  always_comb begin
    diff    = gray ^ prev_gray_q;
    err_new = (state_q == S_TRACK) && ($countones(diff) != 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray_q <= '0;
      step_err    <= 1'b0;
      err_count   <= '0;
    end else if (accept) begin
      prev_gray_q <= gray;
      step_err    <= err_new;
      if (err_new && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule
